// File: rtl/ps2_pet_keyboard.sv
// rtl/ps2_pet_keyboard.sv - PS/2 keyboard receiver driving a PET 10x8 key matrix
// Scancodes set/clear matrix cells; keyin reads the selected row with active-low columns.
module ps2_pet_keyboard #(
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [3:0] keyrow,
  output logic [7:0] keyin,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;

  state_t                 state_q;
  logic [2:0]             bitcnt_q;
  logic [7:0]             shift_q;
  logic                   parity_q;
  logic [TW-1:0]          tmo_q;
  logic                   scan_valid_q;
  logic                   frame_err_q;
  logic                   clr_flags_q;
  logic [7:0]             scan_code_q;

  logic                   ext_q;
  logic                   brk_q;
  logic [7:0]             matrix_q [10];

  logic [7:0]             map_e;
  logic                   map_hit;
  logic [3:0]             map_row;
  logic [2:0]             map_col;

  // Synchronisers idle high so reset release never fakes a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_s;
    end
  end

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bitcnt_q     <= 3'd0;
      shift_q      <= 8'h00;
      parity_q     <= 1'b0;
      tmo_q        <= '0;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      clr_flags_q  <= 1'b0;
      scan_code_q  <= 8'h00;
    end else begin
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      clr_flags_q  <= 1'b0;

      if (fall) begin
        tmo_q <= '0;
      end else if (state_q != S_IDLE) begin
        tmo_q <= tmo_q + TW'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (fall) begin
            if (!data_s) begin
              state_q  <= S_DATA;
              bitcnt_q <= 3'd0;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (fall) begin
            shift_q  <= {data_s, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              state_q <= S_PARITY;
            end
          end
        end
        S_PARITY: begin
          if (fall) begin
            parity_q <= data_s;
            state_q  <= S_STOP;
          end
        end
        S_STOP: begin
          if (fall) begin
            // Odd parity over data plus parity bit, and stop bit must be high.
            if (data_s && (^{shift_q, parity_q})) begin
              scan_valid_q <= 1'b1;
              scan_code_q  <= shift_q;
            end else begin
              frame_err_q <= 1'b1;
              clr_flags_q <= 1'b1;
            end
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (!fall && (state_q != S_IDLE) && (tmo_q == TMAX)) begin
        state_q     <= S_IDLE;
        tmo_q       <= '0;
        frame_err_q <= 1'b1;
        clr_flags_q <= 1'b1;
      end
    end
  end

  assign scan_valid = scan_valid_q;
  assign frame_err  = frame_err_q;
  assign scan_code  = scan_code_q;

  // Keymap ROM: {ext, code} -> {hit, row[3:0], col[2:0]}; every cell used at most once.
  always_comb begin
    map_e = 8'h00;
    case ({ext_q, scan_code_q})
      9'h015: map_e = {1'b1, 4'd2, 3'd0};  // Q
      9'h024: map_e = {1'b1, 4'd2, 3'd1};  // E
      9'h02C: map_e = {1'b1, 4'd2, 3'd2};  // T
      9'h03C: map_e = {1'b1, 4'd2, 3'd3};  // U
      9'h044: map_e = {1'b1, 4'd2, 3'd4};  // O
      9'h03D: map_e = {1'b1, 4'd2, 3'd6};  // 7
      9'h046: map_e = {1'b1, 4'd2, 3'd7};  // 9
      9'h01D: map_e = {1'b1, 4'd3, 3'd0};  // W
      9'h02D: map_e = {1'b1, 4'd3, 3'd1};  // R
      9'h035: map_e = {1'b1, 4'd3, 3'd2};  // Y
      9'h043: map_e = {1'b1, 4'd3, 3'd3};  // I
      9'h04D: map_e = {1'b1, 4'd3, 3'd4};  // P
      9'h03E: map_e = {1'b1, 4'd3, 3'd6};  // 8
      9'h04A: map_e = {1'b1, 4'd3, 3'd7};  // /
      9'h01C: map_e = {1'b1, 4'd4, 3'd0};  // A
      9'h023: map_e = {1'b1, 4'd4, 3'd1};  // D
      9'h034: map_e = {1'b1, 4'd4, 3'd2};  // G
      9'h03B: map_e = {1'b1, 4'd4, 3'd3};  // J
      9'h04B: map_e = {1'b1, 4'd4, 3'd4};  // L
      9'h025: map_e = {1'b1, 4'd4, 3'd6};  // 4
      9'h036: map_e = {1'b1, 4'd4, 3'd7};  // 6
      9'h01B: map_e = {1'b1, 4'd5, 3'd0};  // S
      9'h02B: map_e = {1'b1, 4'd5, 3'd1};  // F
      9'h033: map_e = {1'b1, 4'd5, 3'd2};  // H
      9'h042: map_e = {1'b1, 4'd5, 3'd3};  // K
      9'h02E: map_e = {1'b1, 4'd5, 3'd6};  // 5
      9'h01A: map_e = {1'b1, 4'd6, 3'd0};  // Z
      9'h021: map_e = {1'b1, 4'd6, 3'd1};  // C
      9'h032: map_e = {1'b1, 4'd6, 3'd2};  // B
      9'h03A: map_e = {1'b1, 4'd6, 3'd3};  // M
      9'h04C: map_e = {1'b1, 4'd6, 3'd4};  // ;
      9'h05A: map_e = {1'b1, 4'd6, 3'd5};  // return
      9'h016: map_e = {1'b1, 4'd6, 3'd6};  // 1
      9'h026: map_e = {1'b1, 4'd6, 3'd7};  // 3
      9'h022: map_e = {1'b1, 4'd7, 3'd0};  // X
      9'h02A: map_e = {1'b1, 4'd7, 3'd1};  // V
      9'h031: map_e = {1'b1, 4'd7, 3'd2};  // N
      9'h041: map_e = {1'b1, 4'd7, 3'd3};  // ,
      9'h01E: map_e = {1'b1, 4'd7, 3'd6};  // 2
      9'h012: map_e = {1'b1, 4'd8, 3'd0};  // left shift
      9'h059: map_e = {1'b1, 4'd8, 3'd5};  // right shift
      9'h045: map_e = {1'b1, 4'd8, 3'd6};  // 0
      9'h04E: map_e = {1'b1, 4'd8, 3'd7};  // -
      9'h029: map_e = {1'b1, 4'd9, 3'd2};  // space
      9'h076: map_e = {1'b1, 4'd9, 3'd4};  // esc -> stop
      9'h049: map_e = {1'b1, 4'd9, 3'd6};  // .
      9'h055: map_e = {1'b1, 4'd9, 3'd7};  // =
      9'h066: map_e = {1'b1, 4'd1, 3'd6};  // backspace -> del
      9'h16C: map_e = {1'b1, 4'd0, 3'd6};  // home
      9'h174: map_e = {1'b1, 4'd0, 3'd7};  // cursor right
      9'h175: map_e = {1'b1, 4'd1, 3'd7};  // cursor up, shares the cursor-down cell
      default: map_e = 8'h00;
    endcase
  end

  assign map_hit = map_e[7];
  assign map_row = map_e[6:3];
  assign map_col = map_e[2:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      for (int r = 0; r < 10; r++) begin
        matrix_q[r] <= 8'h00;
      end
    end else if (clr_flags_q) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (scan_valid_q) begin
      case (scan_code_q)
        8'hE0: ext_q <= 1'b1;
        8'hF0: brk_q <= 1'b1;
        8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
        default: begin
          if (map_hit) begin
            for (int r = 0; r < 10; r++) begin
              if (map_row == 4'(r)) begin
                matrix_q[r][map_col] <= ~brk_q;
              end
            end
          end
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    keyin = 8'hFF;
    for (int r = 0; r < 10; r++) begin
      if (keyrow == 4'(r)) begin
        keyin = ~matrix_q[r];
      end
    end
  end

endmodule

// File: tb/tb_ps2_pet_keyboard.sv
// tb/tb_ps2_pet_keyboard.sv - bench for ps2_pet_keyboard
// Scancode scoreboard plus a table of key press/release vectors and hand-written corner cases.
module tb_ps2_pet_keyboard;

  localparam int TMO  = 1000;
  localparam int HALF = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] keyrow = 4'd0;
  logic [7:0] keyin;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       frame_err;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         n_err = 0;
  int         e0;
  logic [7:0] sb [$];
  logic [7:0] exp_code;

  typedef struct {
    int          n;
    logic [23:0] b;
    logic [3:0]  row;
    logic [7:0]  exp;
  } vec_t;

  vec_t vt [16];

  always #5 clk = ~clk;

  ps2_pet_keyboard #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .keyrow     (keyrow),
    .keyin      (keyin),
    .scan_valid (scan_valid),
    .scan_code  (scan_code),
    .frame_err  (frame_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) n_err++;
      if (scan_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_scan: got %0h expected no frame", scan_code);
        end else begin
          exp_code = sb.pop_front();
          chk("scan_code", {24'h0, scan_code}, {24'h0, exp_code});
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    wait_clk(HALF);
    ps2_clk = 1'b0;
    wait_clk(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad);
    logic p;
    p = (~^b) ^ bad;
    if (!bad) sb.push_back(b);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(1'b1);
    wait_clk(20);
  endtask

  task automatic read_row(input string name, input logic [3:0] r, input logic [7:0] exp);
    keyrow = r;
    #1;
    chk(name, {24'h0, keyin}, {24'h0, exp});
  endtask

  initial begin
    vt[0]  = '{1, 24'h1C0000, 4'd4, 8'hFE};
    vt[1]  = '{2, 24'hF01C00, 4'd4, 8'hFF};
    vt[2]  = '{1, 24'h120000, 4'd8, 8'hFE};
    vt[3]  = '{1, 24'h290000, 4'd9, 8'hFB};
    vt[4]  = '{2, 24'hF01200, 4'd8, 8'hFF};
    vt[5]  = '{0, 24'h000000, 4'd9, 8'hFB};
    vt[6]  = '{1, 24'h5A0000, 4'd6, 8'hDF};
    vt[7]  = '{1, 24'h160000, 4'd6, 8'h9F};
    vt[8]  = '{1, 24'h590000, 4'd8, 8'hDF};
    vt[9]  = '{2, 24'hE07500, 4'd1, 8'h7F};
    vt[10] = '{1, 24'h750000, 4'd1, 8'h7F};
    vt[11] = '{1, 24'hAA0000, 4'd1, 8'h7F};
    vt[12] = '{3, 24'hE0F075, 4'd1, 8'hFF};
    vt[13] = '{2, 24'hF02900, 4'd9, 8'hFF};
    vt[14] = '{2, 24'hF05A00, 4'd6, 8'hBF};
    vt[15] = '{1, 24'h1B0000, 4'd5, 8'hFE};

    wait_clk(5);
    reset = 1'b0;
    wait_clk(3);
    for (int r = 0; r < 16; r++) read_row($sformatf("reset_row%0d", r), 4'(r), 8'hFF);
    chk("reset_scan_code", {24'h0, scan_code}, 32'h0);
    chk("reset_scan_valid", {31'h0, scan_valid}, 32'h0);
    chk("reset_frame_err", {31'h0, frame_err}, 32'h0);

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < vt[i].n; j++) send_byte(vt[i].b[23-8*j -: 8], 1'b0);
      read_row($sformatf("vec%0d", i), vt[i].row, vt[i].exp);
      chk($sformatf("vec%0d_drain", i), sb.size(), 32'h0);
    end
    chk("vec_no_err", n_err, 32'h0);

    e0 = n_err;
    send_byte(8'h1C, 1'b1);
    chk("parity_err", n_err, e0 + 1);
    read_row("parity_row4", 4'd4, 8'hFF);

    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b1);
    send_byte(8'h1C, 1'b0);
    read_row("reject_clears_brk", 4'd4, 8'hFE);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    read_row("release_a", 4'd4, 8'hFF);

    e0 = n_err;
    ps2_data = 1'b1;
    wait_clk(HALF);
    ps2_clk = 1'b0;
    wait_clk(HALF);
    ps2_clk = 1'b1;
    wait_clk(20);
    chk("start_bit_err", n_err, e0 + 1);

    e0 = n_err;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'(i & 1));
    wait_clk(TMO - 100);
    chk("timeout_not_early", n_err, e0);
    wait_clk(150);
    chk("timeout_err", n_err, e0 + 1);
    send_byte(8'h1C, 1'b0);
    read_row("after_timeout", 4'd4, 8'hFE);
    chk("after_timeout_drain", sb.size(), 32'h0);

    ps2_bit(1'b0);
    ps2_bit(1'b1);
    reset = 1'b1;
    wait_clk(3);
    for (int r = 0; r < 16; r++) read_row($sformatf("midreset_row%0d", r), 4'(r), 8'hFF);
    chk("midreset_scan_code", {24'h0, scan_code}, 32'h0);
    ps2_data = 1'b1;
    reset = 1'b0;
    wait_clk(5);
    send_byte(8'h29, 1'b0);
    read_row("post_reset_space", 4'd9, 8'hFB);
    read_row("post_reset_row4", 4'd4, 8'hFF);
    chk("final_drain", sb.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
